// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bundle: memory request/response port plus the decode-side FIFO head.
// master = fetch unit, slave = memory/decode environment.
interface ifetch_unit_if #(
  parameter int unsigned NBITS = 32
);
  logic             iproc_req;
  logic             imem_rdy;
  logic [NBITS-1:0] iaddr;
  logic [NBITS-1:0] idata;
  logic             ivalid;
  logic             if_valid;
  logic [NBITS-1:0] if_instr;
  logic [NBITS-1:0] if_pc;
  logic             id_ready;

  modport master (
    output iproc_req, iaddr, if_valid, if_instr, if_pc,
    input  imem_rdy, idata, ivalid, id_ready
  );

  modport slave (
    input  iproc_req, iaddr, if_valid, if_instr, if_pc,
    output imem_rdy, idata, ivalid, id_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding memory request, credit-limited by a small
// PC/instruction FIFO feeding decode; redirects flush the FIFO and drop in-flight responses.
module ifetch_unit #(
  parameter int unsigned      NBITS      = 32,
  parameter int unsigned      FIFO_DEPTH = 2,
  parameter logic [NBITS-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             rstn,
  ifetch_unit_if.master    bus,
  input  logic             redirect,
  input  logic [NBITS-1:0] redirect_pc
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [NBITS-1:0] req_pc_q, req_pc_d;
  logic             discard_q, discard_d;

  logic [NBITS-1:0] instr_mem_q [FIFO_DEPTH];
  logic [NBITS-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic accept, resp, push, pop;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign accept = (state_q == REQ) && bus.imem_rdy;
  assign resp   = (state_q == WAIT) && bus.ivalid;
  assign push   = resp && !discard_q && !redirect;
  assign pop    = (count_q != '0) && bus.id_ready && !redirect;

  assign bus.iproc_req = (state_q == REQ);
  assign bus.iaddr     = fetch_pc_q;
  assign bus.if_valid  = (count_q != '0);
  assign bus.if_instr  = instr_mem_q[rd_ptr_q];
  assign bus.if_pc     = pc_mem_q[rd_ptr_q];

  // Credit uses registered occupancy only; an outstanding request is implied by WAIT.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    case (state_q)
      HOLD: if (count_q < Depth) state_d = REQ;
      REQ: begin
        if (accept) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + NBITS'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.ivalid) begin
          discard_d = 1'b0;
          state_d   = ((count_q + CntW'(push)) < Depth) ? REQ : HOLD;
        end
      end
      default: state_d = HOLD;
    endcase

    if (redirect) begin
      fetch_pc_d = {redirect_pc[NBITS-1:2], 2'b00};
      // A request still owed a response must have that response dropped.
      if (accept || ((state_q == WAIT) && !bus.ivalid)) begin
        state_d   = WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = HOLD;
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= HOLD;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_mem_q[wr_ptr_q] <= bus.idata;
        pc_mem_q[wr_ptr_q]    <= req_pc_q;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a latency-programmable memory responder and a linear
// sequence of fetch, back-pressure, redirect and reset scenarios.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_pass  = 0;
  int n_total = 0;

  int          mem_lat;
  logic        pend;
  int          wait_cnt;
  logic [31:0] pend_addr;

  ifetch_unit_if #(.NBITS(32)) bus ();

  ifetch_unit #(
    .NBITS     (32),
    .FIFO_DEPTH(2),
    .RESET_PC  (32'h0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory word at address a is 0xDEAD in the top half and a[15:0] in the bottom half.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend       <= 1'b0;
      wait_cnt   <= 0;
      pend_addr  <= '0;
      bus.ivalid <= 1'b0;
      bus.idata  <= '0;
    end else begin
      bus.ivalid <= 1'b0;
      if (pend) begin
        if (wait_cnt <= 1) begin
          bus.ivalid <= 1'b1;
          bus.idata  <= {16'hDEAD, pend_addr[15:0]};
          pend       <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end
      if (bus.iproc_req && bus.imem_rdy) begin
        if (mem_lat <= 1) begin
          bus.ivalid <= 1'b1;
          bus.idata  <= {16'hDEAD, bus.iaddr[15:0]};
        end else begin
          pend      <= 1'b1;
          pend_addr <= bus.iaddr;
          wait_cnt  <= mem_lat - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next valid FIFO head and checks its PC and instruction.
  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      seen = bus.if_valid;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_pc"}, bus.if_pc, pc);
    check({tag, "_instr"}, bus.if_instr, instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic saw;
    rstn         = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    bus.imem_rdy = 1'b1;
    bus.id_ready = 1'b1;
    mem_lat      = 1;
    step();
    step();
    check("rst_req", 32'(bus.iproc_req), 32'd0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_instr", bus.if_instr, 32'h0);
    check("rst_pc", bus.if_pc, 32'h0);
    rstn = 1'b1;

    // Zero-wait streaming
    expect_head("t1_0", 32'h0, 32'hDEAD_0000);
    expect_head("t1_4", 32'h4, 32'hDEAD_0004);
    expect_head("t1_8", 32'h8, 32'hDEAD_0008);
    expect_head("t1_c", 32'hC, 32'hDEAD_000C);

    // Decode stall: FIFO fills to two entries and fetch holds
    bus.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_req", 32'(bus.iproc_req), 32'd0);
    end
    check("t2_head_valid", 32'(bus.if_valid), 32'd1);
    check("t2_head_pc", bus.if_pc, 32'hC);
    bus.id_ready = 1'b1;
    expect_head("t2_10", 32'h10, 32'hDEAD_0010);
    expect_head("t2_14", 32'h14, 32'hDEAD_0014);
    expect_head("t2_18", 32'h18, 32'hDEAD_0018);

    // Redirect while waiting on a slow response
    mem_lat = 3;
    for (int i = 0; i < 10 && !bus.iproc_req; i++) step();
    check("t3_req_addr", bus.iaddr, 32'h1C);
    step();
    check("t3_in_wait", 32'(bus.iproc_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    check("t3_post_req", 32'(bus.iproc_req), 32'd0);
    check("t3_post_valid", 32'(bus.if_valid), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 20 && !bus.iproc_req; i++) begin
      step();
      saw |= bus.if_valid;
    end
    check("t3_no_stale", 32'(saw), 32'd0);
    check("t3_new_req", 32'(bus.iproc_req), 32'd1);
    check("t3_new_iaddr", bus.iaddr, 32'h100);
    expect_head("t3_100", 32'h100, 32'hDEAD_0100);

    // Redirect coinciding with a response and a decode pop
    mem_lat      = 1;
    bus.id_ready = 1'b0;
    step();
    check("t4_held_valid", 32'(bus.if_valid), 32'd1);
    check("t4_held_pc", bus.if_pc, 32'h100);
    bus.id_ready = 1'b1;
    redirect     = 1'b1;
    redirect_pc  = 32'h200;
    step();
    redirect = 1'b0;
    check("t4_flush_valid", 32'(bus.if_valid), 32'd0);
    check("t4_flush_req", 32'(bus.iproc_req), 32'd0);
    step();
    check("t4_new_req", 32'(bus.iproc_req), 32'd1);
    check("t4_new_iaddr", bus.iaddr, 32'h200);
    expect_head("t4_200", 32'h200, 32'hDEAD_0200);

    // Memory not ready for three cycles, then redirect aborts the request
    bus.imem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_req", 32'(bus.iproc_req), 32'd1);
      check("t5_stall_iaddr", bus.iaddr, 32'h204);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect     = 1'b0;
    bus.imem_rdy = 1'b1;
    check("t5_abort_req", 32'(bus.iproc_req), 32'd0);
    step();
    check("t5_reissue_req", 32'(bus.iproc_req), 32'd1);
    check("t5_reissue_iaddr", bus.iaddr, 32'h300);
    expect_head("t5_300", 32'h300, 32'hDEAD_0300);

    // Asynchronous reset while a request is outstanding
    mem_lat      = 3;
    bus.id_ready = 1'b0;
    step();
    check("t6_pre_req", 32'(bus.iproc_req), 32'd0);
    check("t6_pre_valid", 32'(bus.if_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("t6_rst_iaddr", bus.iaddr, 32'h0);
    check("t6_rst_valid", 32'(bus.if_valid), 32'd0);
    check("t6_rst_pc", bus.if_pc, 32'h0);
    check("t6_rst_instr", bus.if_instr, 32'h0);
    step();
    rstn         = 1'b1;
    bus.id_ready = 1'b1;
    mem_lat      = 1;
    expect_head("t6_0", 32'h0, 32'hDEAD_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
